pulse_bram_reader: RTL and testbench
====================================

Name: pulse_bram_reader

Overview:
- Read-out end of the pulse accumulation buffer. The pulse generators write fp32 pulse shapes additively into the BRAM.
- This block walks that BRAM circularly at a fixed sample rate and presents each word as an fp32 sample on a valid/ready stream toward the DAC/output path.
- Each location is cleared to 0.0 (32'h00000000) after it is read, so the buffer acts as a read-and-clear ring.
- It owns BRAM port B. The generators own port A.

Parameters:
- DEPTH, 2048, number of 32-bit words in the ring (power of two).
- ADDR_STRIDE, 4, byte stride per word on bram_addr.
- TICK_DIV, 100, clk cycles per output sample period (≥ 8).
- RD_LATENCY, 1, cycles from the BRAM address-sample edge to valid bram_data_out.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  run read-out; 0 pauses at next sample boundary
- bram_addr  out  32  byte address, port B
- bram_data_in  out  32  write data, port B (always 0 when written)
- bram_we  out  1  port B write enable
- bram_ena  out  1  port B enable
- bram_data_out  in  32  port B read data
- sample_data  out  32  fp32 sample
- sample_valid  out  1  sample_data valid
- sample_ready  in  1  downstream accept
- rd_ptr  out  $clog2(DEPTH)  current word index
- drop_count  out  16  samples dropped on backpressure, saturating

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- While rst=1, on the clock edge:
  - bram_addr=0, bram_data_in=0, bram_we=0, bram_ena=0.
  - sample_data=0, sample_valid=0.
  - rd_ptr=0, drop_count=0, tick counter=0, state=IDLE.
- Reset mid-operation aborts any pending clear. The location being processed may keep its value; this is acceptable.
- Tick counter:
  - Counts 0..TICK_DIV-1 while enable=1 and wraps.
  - tick pulses when counter==TICK_DIV-1.
  - Counter holds at 0 while enable=0.
- IDLE:
  - bram_ena=0, bram_we=0.
  - On tick go to RD.
- RD (1 cycle):
  - bram_ena=1, bram_we=0, bram_addr=rd_ptr*ADDR_STRIDE.
  - Go to WAIT.
- WAIT:
  - Hold bram_ena=1 and the address for RD_LATENCY cycles.
  - Then go to CAPTURE.
- CAPTURE (1 cycle): latch bram_data_out.
  - If sample_valid=0 or sample_ready=1 this cycle: sample_data<=latched word, sample_valid<=1.
  - Otherwise the word is discarded and drop_count increments, saturating at 16'hFFFF.
  - Go to CLEAR.
- CLEAR (1 cycle):
  - bram_ena=1, bram_we=1, bram_addr unchanged, bram_data_in=0.
  - rd_ptr<=(rd_ptr+1) mod DEPTH.
  - Go to DONE.
- DONE:
  - bram_we=0, bram_ena=0.
  - Go to IDLE.
- Stream handshake:
  - sample_valid drops on the cycle after sample_valid&&sample_ready, unless CAPTURE loads a new word in that same cycle.
  - sample_data is stable while sample_valid=1 and sample_ready=0.
- Simultaneous events:
  - A CAPTURE in the same cycle as an accept loads the new word; valid stays 1.
  - A tick while not in IDLE cannot occur, because TICK_DIV ≥ 8 exceeds the sequence length of RD_LATENCY+5.
- enable=0:
  - A read sequence already started completes through DONE.
  - No new tick is generated.
  - rd_ptr and drop_count are held.
- Wrap: after index DEPTH-1 the next read is index 0 (byte address 0).
- Latency: first sample_valid rises TICK_DIV+RD_LATENCY+2 cycles after enable rises (default 103). Exactly one sample is produced per TICK_DIV cycles.
- No arithmetic is performed on samples; the fp32 bit pattern passes through unchanged.

Decomposition:
- Shared package pulse_pkg:
  - FP32_ZERO = 32'h00000000.
  - BRAM_STRIDE=4 and PULSE_TAPS=13, both shared with the generators.
  - Reader state enum {IDLE, RD, WAIT, CAPTURE, CLEAR, DONE}.
- One natural sub-module: sample_tick_gen (parameter TICK_DIV; enable in, tick out).
- The stream output register stays inline.

Test Plan:
- Reset/idle: rst=1 for 3 cycles, then enable=0 for 200 cycles → all outputs 0, bram_ena never asserted, rd_ptr=0.
- Read-and-clear: preload words 0..2 = 3D7C5048, 3E99652C, 3E0E3BCD; enable=1, sample_ready=1 → three samples in that order, 100 cycles apart, first at cycle 103. After each read, a write of 0 occurs at the same address (0, 4, 8). Re-reading words 0..2 over port A returns 0.
- Backpressure: sample_ready=0 for 3 tick periods with preloaded non-zero words → sample_data holds the first word, drop_count=2, and every word is still cleared.
- Wrap: DEPTH=16, TICK_DIV=8; run 20 samples → bram_addr sequence 0, 4, …, 60, 0, 4, 8, 12; rd_ptr returns to 0 after the 16th sample.
- Pause/reset mid-sequence: drop enable during WAIT → the sequence completes with a clear write, then no further bram_ena. Separately, assert rst during CAPTURE → next-edge outputs 0, state IDLE, no write issued.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared constants and types for the pulse accumulation buffer.
// The generators own BRAM port A; the reader drains port B.
package pulse_pkg;

  localparam logic [31:0] FP32_ZERO   = 32'h0000_0000;
  localparam int unsigned BRAM_STRIDE = 4;
  localparam int unsigned PULSE_TAPS  = 13;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    CAPTURE,
    CLEAR,
    DONE
  } reader_state_e;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period strobe: one tick every TICK_DIV cycles while enabled.
// The counter parks at zero while disabled so a restart begins a full period.
module sample_tick_gen #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/pulse_bram_reader.sv
// Read-and-clear drain of the pulse ring: one fp32 word per sample period is read
// from port B, offered on a valid/ready stream, and overwritten with 0.0.
module pulse_bram_reader
  import pulse_pkg::*;
#(
  parameter int unsigned DEPTH       = 2048,
  parameter int unsigned ADDR_STRIDE = BRAM_STRIDE,
  parameter int unsigned TICK_DIV    = 100,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  output logic [31:0]              bram_addr,
  output logic [31:0]              bram_data_in,
  output logic                     bram_we,
  output logic                     bram_ena,
  input  logic [31:0]              bram_data_out,
  output logic [31:0]              sample_data,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [15:0]              drop_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [WW-1:0] LAST_WAIT = WW'(RD_LATENCY - 1);

  reader_state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic [15:0]   drop_q, drop_d;
  logic          tick;
  logic          port_active;

  sample_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wait_d  = wait_q;
    data_d  = data_q;
    valid_d = valid_q;
    drop_d  = drop_q;

    if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (tick) state_d = RD;
      end
      RD: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == LAST_WAIT) begin
          state_d = CAPTURE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      CAPTURE: begin
        // A word that finds the output register still occupied is lost, not queued.
        if (!valid_q || sample_ready) begin
          data_d  = bram_data_out;
          valid_d = 1'b1;
        end else if (drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
        state_d = CLEAR;
      end
      CLEAR: begin
        ptr_d   = ptr_q + PW'(1);
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      wait_q  <= '0;
      data_q  <= FP32_ZERO;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  // Port B stays enabled with a steady address from RD through the clearing write.
  assign port_active  = (state_q == RD) || (state_q == WAIT) ||
                        (state_q == CAPTURE) || (state_q == CLEAR);
  assign bram_ena     = port_active;
  assign bram_we      = (state_q == CLEAR);
  assign bram_addr    = port_active ? (32'(ptr_q) * 32'(ADDR_STRIDE)) : 32'd0;
  assign bram_data_in = FP32_ZERO;

  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign rd_ptr       = ptr_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_pulse_bram_reader.sv
// Bench for pulse_bram_reader: a default-size instance for timing/backpressure/reset
// sequences and a 16-deep, 8-cycle instance for wrap and randomized checks.
module tb_pulse_bram_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  // ---------------- instance A: default parameters ----------------
  logic        a_rst = 1'b1, a_en = 1'b0, a_ready = 1'b1;
  logic [31:0] a_addr, a_din, a_dout, a_sdata;
  logic        a_we, a_ena, a_svalid;
  logic [10:0] a_ptr;
  logic [15:0] a_drops;
  logic [31:0] mem_a [2048];
  logic        pa_we = 1'b0;
  logic [10:0] pa_idx = '0;
  logic [31:0] pa_wdata = '0;
  logic [31:0] a_wr_log [64];
  int          a_wr_cnt = 0;
  int          a_ena_cnt = 0;

  always @(posedge clk) begin
    if (pa_we) mem_a[pa_idx] <= pa_wdata;
    if (a_ena) begin
      a_dout <= mem_a[a_addr[12:2]];
      if (a_we) begin
        mem_a[a_addr[12:2]] <= a_din;
        if (a_wr_cnt < 64) a_wr_log[a_wr_cnt] <= a_addr;
        a_wr_cnt <= a_wr_cnt + 1;
      end
      a_ena_cnt <= a_ena_cnt + 1;
    end
  end

  pulse_bram_reader u_dut (
    .clk           (clk),
    .rst           (a_rst),
    .enable        (a_en),
    .bram_addr     (a_addr),
    .bram_data_in  (a_din),
    .bram_we       (a_we),
    .bram_ena      (a_ena),
    .bram_data_out (a_dout),
    .sample_data   (a_sdata),
    .sample_valid  (a_svalid),
    .sample_ready  (a_ready),
    .rd_ptr        (a_ptr),
    .drop_count    (a_drops)
  );

  // ---------------- instance B: DEPTH=16, TICK_DIV=8 ----------------
  logic        b_rst = 1'b1, b_en = 1'b0, b_ready = 1'b1;
  logic [31:0] b_addr, b_din, b_dout, b_sdata;
  logic        b_we, b_ena, b_svalid;
  logic [3:0]  b_ptr;
  logic [15:0] b_drops;
  logic [31:0] mem_b [16];
  logic        pb_we = 1'b0;
  logic [3:0]  pb_idx = '0;
  logic [31:0] pb_wdata = '0;
  logic [31:0] b_wr_log [64];
  int          b_wr_cnt = 0;

  always @(posedge clk) begin
    if (pb_we) mem_b[pb_idx] <= pb_wdata;
    if (b_ena) begin
      b_dout <= mem_b[b_addr[5:2]];
      if (b_we) begin
        mem_b[b_addr[5:2]] <= b_din;
        if (b_wr_cnt < 64) b_wr_log[b_wr_cnt] <= b_addr;
        b_wr_cnt <= b_wr_cnt + 1;
      end
    end
  end

  pulse_bram_reader #(.DEPTH(16), .TICK_DIV(8)) u_wrap (
    .clk           (clk),
    .rst           (b_rst),
    .enable        (b_en),
    .bram_addr     (b_addr),
    .bram_data_in  (b_din),
    .bram_we       (b_we),
    .bram_ena      (b_ena),
    .bram_data_out (b_dout),
    .sample_data   (b_sdata),
    .sample_valid  (b_svalid),
    .sample_ready  (b_ready),
    .rd_ptr        (b_ptr),
    .drop_count    (b_drops)
  );

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load_a(input int idx, input logic [31:0] w);
    pa_idx   = idx[10:0];
    pa_wdata = w;
    pa_we    = 1'b1;
    step();
    pa_we    = 1'b0;
  endtask

  task automatic load_b(input int idx, input logic [31:0] w);
    pb_idx   = idx[3:0];
    pb_wdata = w;
    pb_we    = 1'b1;
    step();
    pb_we    = 1'b0;
  endtask

  typedef struct {
    int          cyc;
    logic        ena;
    logic        we;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] data;
    logic [10:0] ptr;
  } vec_t;

  localparam logic [31:0] W0 = 32'h3D7C5048;
  localparam logic [31:0] W1 = 32'h3E99652C;
  localparam logic [31:0] W2 = 32'h3E0E3BCD;

  vec_t vecs [12];

  initial begin
    int base_wr;
    int base_ena;
    bit seen16;
    logic [31:0] model_mem [16];
    logic [31:0] word;
    logic [31:0] md;
    logic        mv;
    logic        r;
    int          mp;
    int          mdrop;
    int          knext;

    vecs[0]  = '{99,  1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 11'd0};
    vecs[1]  = '{100, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 11'd0};
    vecs[2]  = '{101, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 11'd0};
    vecs[3]  = '{102, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 11'd0};
    vecs[4]  = '{103, 1'b1, 1'b1, 32'd0, 1'b1, W0,    11'd0};
    vecs[5]  = '{104, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 11'd1};
    vecs[6]  = '{200, 1'b1, 1'b0, 32'd4, 1'b0, 32'd0, 11'd1};
    vecs[7]  = '{203, 1'b1, 1'b1, 32'd4, 1'b1, W1,    11'd1};
    vecs[8]  = '{204, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 11'd2};
    vecs[9]  = '{300, 1'b1, 1'b0, 32'd8, 1'b0, 32'd0, 11'd2};
    vecs[10] = '{303, 1'b1, 1'b1, 32'd8, 1'b1, W2,    11'd2};
    vecs[11] = '{304, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 11'd3};

    // Reset then idle with enable low.
    repeat (3) step();
    check("rst.valid", a_svalid, 0);
    check("rst.data", a_sdata, 0);
    check("rst.ena", a_ena, 0);
    check("rst.ptr", a_ptr, 0);
    check("rst.drops", a_drops, 0);
    check("rst_b.valid", b_svalid, 0);
    a_rst = 1'b0;
    repeat (200) step();
    check("idle.ena_cycles", a_ena_cnt, 0);
    check("idle.we", a_we, 0);
    check("idle.addr", a_addr, 0);
    check("idle.valid", a_svalid, 0);
    check("idle.ptr", a_ptr, 0);

    // Read-and-clear of three preloaded words.
    load_a(0, W0);
    load_a(1, W1);
    load_a(2, W2);
    a_ready = 1'b1;
    a_en = 1'b1;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      while (k < vecs[i].cyc) step();
      check($sformatf("rc@%0d.ena", vecs[i].cyc), a_ena, vecs[i].ena);
      check($sformatf("rc@%0d.we", vecs[i].cyc), a_we, vecs[i].we);
      if (vecs[i].ena) check($sformatf("rc@%0d.addr", vecs[i].cyc), a_addr, vecs[i].addr);
      check($sformatf("rc@%0d.valid", vecs[i].cyc), a_svalid, vecs[i].valid);
      if (vecs[i].valid) begin
        check($sformatf("rc@%0d.data", vecs[i].cyc), a_sdata, vecs[i].data);
        $display("sample at cycle %0d data=%h", k, a_sdata);
      end
      check($sformatf("rc@%0d.ptr", vecs[i].cyc), a_ptr, vecs[i].ptr);
    end
    a_en = 1'b0;
    repeat (3) step();
    check("rc.writes", a_wr_cnt, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rc.clear_addr%0d", i), a_wr_log[i], 32'(i * 4));
      check($sformatf("rc.word%0d_zero", i), mem_a[i], 0);
    end

    // Backpressure: ready low for three tick periods.
    load_a(3, 32'h3F800000);
    load_a(4, 32'h40000000);
    load_a(5, 32'hC0400000);
    a_ready = 1'b0;
    a_en = 1'b1;
    k = 0;
    while (k < 150) step();
    check("bp.valid_mid", a_svalid, 1);
    check("bp.data_mid", a_sdata, 32'h3F800000);
    while (k < 305) step();
    check("bp.valid", a_svalid, 1);
    check("bp.data_held", a_sdata, 32'h3F800000);
    check("bp.drops", a_drops, 2);
    check("bp.ptr", a_ptr, 6);
    check("bp.writes", a_wr_cnt, 6);
    for (int i = 3; i < 6; i++) begin
      check($sformatf("bp.clear_addr%0d", i), a_wr_log[i], 32'(i * 4));
      check($sformatf("bp.word%0d_zero", i), mem_a[i], 0);
    end
    a_en = 1'b0;
    a_ready = 1'b1;
    step();
    check("bp.accept_drops_valid", a_svalid, 0);

    // Reset clears non-zero drop count and held sample.
    a_rst = 1'b1;
    repeat (2) step();
    check("rst2.ptr", a_ptr, 0);
    check("rst2.drops", a_drops, 0);
    check("rst2.data", a_sdata, 0);
    a_rst = 1'b0;

    // Pause during WAIT: the sequence still finishes with its clearing write.
    load_a(0, 32'h3F800000);
    base_wr = a_wr_cnt;
    a_en = 1'b1;
    k = 0;
    while (k < 101) step();
    a_en = 1'b0;
    while (k < 103) step();
    check("pause.we", a_we, 1);
    check("pause.addr", a_addr, 0);
    check("pause.valid", a_svalid, 1);
    check("pause.data", a_sdata, 32'h3F800000);
    step();
    check("pause.ena_done", a_ena, 0);
    check("pause.ptr", a_ptr, 1);
    check("pause.writes", a_wr_cnt, 32'(base_wr + 1));
    check("pause.word0_zero", mem_a[0], 0);
    base_ena = a_ena_cnt;
    repeat (300) step();
    check("pause.no_more_ena", a_ena_cnt, 32'(base_ena));
    check("pause.ptr_held", a_ptr, 1);

    // Reset asserted while in CAPTURE: no clearing write, location keeps its value.
    load_a(1, 32'hBF000000);
    base_wr = a_wr_cnt;
    a_en = 1'b1;
    k = 0;
    while (k < 102) step();
    a_rst = 1'b1;
    a_en = 1'b0;
    step();
    check("rstcap.valid", a_svalid, 0);
    check("rstcap.data", a_sdata, 0);
    check("rstcap.ena", a_ena, 0);
    check("rstcap.we", a_we, 0);
    check("rstcap.addr", a_addr, 0);
    check("rstcap.ptr", a_ptr, 0);
    a_rst = 1'b0;
    repeat (5) step();
    check("rstcap.no_write", a_wr_cnt, 32'(base_wr));
    check("rstcap.word_kept", mem_a[1], 32'hBF000000);

    // Wrap on the 16-deep instance.
    b_rst = 1'b0;
    for (int i = 0; i < 16; i++) load_b(i, 32'(i + 1));
    b_ready = 1'b1;
    b_en = 1'b1;
    k = 0;
    seen16 = 1'b0;
    while (b_wr_cnt < 20 && k < 400) begin
      step();
      if (b_wr_cnt == 16 && !seen16) begin
        seen16 = 1'b1;
        check("wrap.ptr_after16", b_ptr, 0);
      end
    end
    b_en = 1'b0;
    check("wrap.writes", b_wr_cnt, 20);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("wrap.addr%0d", i), b_wr_log[i], 32'((i % 16) * 4));
    end
    repeat (4) step();
    check("wrap.ptr_final", b_ptr, 4);

    // Randomized ready against a ring-buffer reference model.
    b_rst = 1'b1;
    repeat (2) step();
    b_rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = $urandom;
      load_b(i, model_mem[i]);
    end
    mp = 0;
    mv = 1'b0;
    md = '0;
    mdrop = 0;
    b_en = 1'b1;
    k = 0;
    while (k < 301) begin
      r = ($urandom_range(0, 1) == 1);
      b_ready = r;
      knext = k + 1;
      if (knext >= 11 && ((knext - 11) % 8) == 0) begin
        word = model_mem[mp];
        model_mem[mp] = '0;
        mp = (mp + 1) % 16;
        if (!mv || r) begin
          md = word;
          mv = 1'b1;
          $display("rand cycle %0d delivered %h", knext, word);
        end else begin
          if (mdrop < 16'hFFFF) mdrop++;
          $display("rand cycle %0d dropped %h", knext, word);
        end
      end else if (mv && r) begin
        mv = 1'b0;
      end
      step();
      check($sformatf("rand@%0d.valid", k), b_svalid, mv);
      if (mv) check($sformatf("rand@%0d.data", k), b_sdata, md);
      check($sformatf("rand@%0d.drops", k), b_drops, 32'(mdrop));
    end
    b_en = 1'b0;
    repeat (6) step();
    check("rand.ptr", b_ptr, 32'(mp));
    for (int i = 0; i < 16; i++) begin
      check($sformatf("rand.mem%0d", i), mem_b[i], model_mem[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
